rf_write_scheduler: RTL
=======================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 3, register index width (8 registers).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  input  ADDR_W  requester 0 destination register.
REQ-007 req0_data  input  DATA_W  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 req1_valid  input  1  requester 1 (load writeback) has a write pending.
REQ-010 req1_addr  input  ADDR_W  requester 1 destination register.
REQ-011 req1_data  input  DATA_W  requester 1 write data.
REQ-012 req1_ready  output  1  requester 1 write accepted this cycle.
REQ-013 rf_we  output  1  register-file write enable, registered.
REQ-014 rf_waddr  output  ADDR_W  register-file write index, registered.
REQ-015 rf_wdata  output  DATA_W  register-file write data, registered.
REQ-016 init_done  output  1  register-file clear sequence complete, registered.

Function
REQ-017 Two states, INIT and ARB; INIT entered on reset; INIT -> ARB after last clear write; ARB held until reset.
REQ-018 INIT: 3-bit clear counter from 0; each edge drives rf_we=1, rf_waddr=counter, rf_wdata=0, then increments the counter.
REQ-019 Clear timing: edges 1..8 after rst_n release write registers 0..7 in order; edge 9 drives rf_we=0, init_done=1, state=ARB.
REQ-020 INIT: req0_ready=req1_ready=0 regardless of valid.
REQ-021 ARB: ready outputs combinational from state, valids and round-robin pointer; no valid-to-ready dependency through registers.
REQ-022 Transfer occurs when reqN_valid && reqN_ready; at most one ready high per cycle.
REQ-023 ARB, only one valid: that requester granted.
REQ-024 ARB, both valid: requester named by 1-bit pointer granted; the other sees ready=0 and holds its inputs stable.
REQ-025 Pointer updates only on a transfer: set to the requester not granted; no transfer leaves it unchanged.
REQ-026 Write latency 1: transfer at edge N's cycle -> rf_we=1, rf_waddr/rf_wdata = granted addr/data after edge N.
REQ-027 Cycle with no transfer in ARB -> rf_we=0 after the next edge; rf_waddr/rf_wdata hold last value.
REQ-028 Back-to-back transfers sustain one write per cycle; no bubble.
REQ-029 Same address from both requesters: only granted write issued; the other issued later by normal arbitration; no merging or dropping.
REQ-030 Address 0 is not special; writes to register 0 are issued like any other.
REQ-031 Valid deasserted before grant: request ignored; no write issued.

Reset
REQ-032 rst_n low asynchronously forces: state=INIT, clear counter=0, pointer=0 (requester 0 priority), rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0.
REQ-033 Ready outputs are 0 while rst_n is low.
REQ-034 Reset asserted mid-clear or mid-arbitration aborts in-flight work; a write accepted in the cycle of reset assertion is discarded; clear restarts from register 0 after release.

Verification
REQ-035 Release rst_n, no requests -> 8 consecutive rf_we=1 cycles, rf_waddr 0..7, rf_wdata=0; then rf_we=0, init_done=1.
REQ-036 Assert req0_valid with addr 3, data 0xDEADBEEF during INIT -> ready 0 until ARB; ready asserted in first ARB cycle; next edge rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF.
REQ-037 Both valid continuously in ARB (req0 addr 1 data 0x11, req1 addr 2 data 0x22), pointer 0 -> grants alternate 0,1,0,1; writes alternate addr 1/2 with no idle cycle.
REQ-038 Both valid, same addr 5 (data 0xA then 0xB), pointer 1 -> req1 written first (0xB), req0 next cycle (0xA); register 5 ends at 0xA.
REQ-039 Assert rst_n low while counter=4 or mid-burst -> outputs zero immediately, without waiting for a clock edge; after release, clear restarts at register 0, pointer=0.
REQ-040 Single valid pulse withdrawn while other requester holds the grant -> no write for the withdrawn request; rf_we count equals transfer count.

Source files
------------

// File: rtl/rf_write_scheduler.sv
// ----------------------------------------------------------------------------
// rf_write_scheduler
//
// Purpose:
//   Owns the single write port of a small register file. After reset it clears
//   every register to zero, one register per clock. It then arbitrates between
//   two writeback requesters (ALU and load) using a round-robin pointer and
//   issues one registered write per clock.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req0_valid  in   requester 0 (ALU writeback) has a write pending
//   req0_addr   in   requester 0 destination register   [ADDR_W]
//   req0_data   in   requester 0 write data             [DATA_W]
//   req0_ready  out  requester 0 write accepted this cycle (combinational)
//   req1_valid  in   requester 1 (load writeback) has a write pending
//   req1_addr   in   requester 1 destination register   [ADDR_W]
//   req1_data   in   requester 1 write data             [DATA_W]
//   req1_ready  out  requester 1 write accepted this cycle (combinational)
//   rf_we       out  register-file write enable         (registered)
//   rf_waddr    out  register-file write index          (registered)
//   rf_wdata    out  register-file write data           (registered)
//   init_done   out  clear sequence complete            (registered)
// ----------------------------------------------------------------------------
module rf_write_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_ONE = 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    // Set once the last register has been cleared; the counter itself wraps
    // back to zero at that point, so it alone cannot mark the final edge.
    logic              r_clr_wrap;
    // Round-robin pointer: names the requester that wins when both are valid.
    logic              r_ptr;

    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_init_done;

    logic              w_arb;
    logic              w_grant0;
    logic              w_grant1;

    // Grants are purely combinational from state, valids and pointer so a
    // requester sees ready in the same cycle it raises valid. Because r_state
    // is reset asynchronously to ST_INIT, both readies drop as soon as rst_n
    // goes low.
    assign w_arb    = (r_state == ST_ARB);
    assign w_grant0 = w_arb && req0_valid && (!req1_valid || (r_ptr == 1'b0));
    assign w_grant1 = w_arb && req1_valid && (!req0_valid || (r_ptr == 1'b1));

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would let later statements see
    // already-updated state and create order-dependent behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= '0;
            r_clr_wrap  <= 1'b0;
            r_ptr       <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_clr_wrap) begin
                        r_rf_we     <= 1'b0;
                        r_init_done <= 1'b1;
                        r_state     <= ST_ARB;
                    end else begin
                        r_rf_we    <= 1'b1;
                        r_rf_waddr <= r_clr_cnt;
                        r_rf_wdata <= '0;
                        r_clr_cnt  <= r_clr_cnt + CNT_ONE;
                        if (r_clr_cnt == '1) begin
                            r_clr_wrap <= 1'b1;
                        end
                    end
                end

                ST_ARB: begin
                    r_rf_we <= w_grant0 || w_grant1;
                    // Address/data hold their last value on idle cycles.
                    if (w_grant0) begin
                        r_rf_waddr <= req0_addr;
                        r_rf_wdata <= req0_data;
                        r_ptr      <= 1'b1;
                    end else if (w_grant1) begin
                        r_rf_waddr <= req1_addr;
                        r_rf_wdata <= req1_data;
                        r_ptr      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign init_done = r_init_done;

endmodule
